// File: rtl/branch_pkg.sv
// Shared types and operand-need lookup for the ID-stage branch controller.
package branch_pkg;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        BEQ  = 3'd1,
        BNE  = 3'd2,
        BGTZ = 3'd3,
        J    = 3'd4,
        JR   = 3'd5
    } br_op_t;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t WAIT = 2'd1;
    localparam state_t DONE = 2'd2;

    typedef struct packed {
        logic rs;
        logic rt;
    } needs_t;

    // Unused codes 6 and 7 fall into default and behave like NONE.
    function automatic needs_t operand_needs(logic [2:0] op);
        needs_t n;
        n = '0;
        case (br_op_t'(op))
            BEQ, BNE: begin
                n.rs = 1'b1;
                n.rt = 1'b1;
            end
            BGTZ, JR: n.rs = 1'b1;
            default:  n = '0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/branch_target.sv
// Combinational branch condition and target computation for the ID stage.
module branch_target
    import branch_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] pc,
    input  logic [15:0] imm16,
    input  logic [25:0] index,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        taken,
    output logic [31:0] target
);

    logic [31:0] pc4;
    logic [31:0] br_tgt;
    logic [31:0] jmp_tgt;

    assign pc4     = pc + 32'd4;
    assign br_tgt  = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign jmp_tgt = {pc4[31:28], index, 2'b00};

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        taken  = 1'b0;
        target = br_tgt;
        case (br_op_t'(op))
            BEQ:  taken = (rs_data == rt_data);
            BNE:  taken = (rs_data != rt_data);
            BGTZ: taken = ($signed(rs_data) > 32'sd0);
            J: begin
                taken  = 1'b1;
                target = jmp_tgt;
            end
            JR: begin
                taken  = 1'b1;
                target = rs_data;
            end
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch sequencer: stalls until operands are final, then issues a
// one-cycle registered PC redirect that keeps the delay slot, plus statistics.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [2:0]       id_br_op,
    input  logic [31:0]      id_pc,
    input  logic [15:0]      id_imm16,
    input  logic [25:0]      id_index,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic             kill,
    output logic             stall_o,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_wait
);

    state_t      state_q, state_d;
    logic        taken_q;
    logic [31:0] target_q;
    logic        cond_taken;
    logic [31:0] cond_target;
    logic        is_branch;
    logic        ready;
    logic        stall;
    logic        latch;
    logic        inc_wait;
    logic        inc_taken;
    needs_t      needs;

    branch_target u_target (
        .op      (id_br_op),
        .pc      (id_pc),
        .imm16   (id_imm16),
        .index   (id_index),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .taken   (cond_taken),
        .target  (cond_target)
    );

    assign needs     = operand_needs(id_br_op);
    assign ready     = (!needs.rs || rs_ready) && (!needs.rt || rt_ready);
    assign is_branch = id_valid && (id_br_op >= 3'd1) && (id_br_op <= 3'd5);

    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        latch     = 1'b0;
        inc_wait  = 1'b0;
        inc_taken = 1'b0;
        if (kill) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_branch) begin
                        stall = 1'b1;
                        if (ready) begin
                            latch   = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    stall    = 1'b1;
                    inc_wait = 1'b1;
                    if (ready) begin
                        latch   = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    inc_taken = taken_q;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Stall is held low while reset is asserted even if a branch sits in ID.
    assign stall_o = stall && rst_n;

    // Redirect depends only on state and latched result, never on ID inputs.
    assign redirect_valid = (state_q == DONE) && taken_q;
    assign redirect_pc    = redirect_valid ? target_q : 32'd0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            taken_q  <= 1'b0;
            target_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                taken_q  <= cond_taken;
                target_q <= cond_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_branch <= '0;
            cnt_taken  <= '0;
            cnt_wait   <= '0;
        end else begin
            if (latch)     cnt_branch <= cnt_branch + 1'b1;
            if (inc_taken) cnt_taken  <= cnt_taken + 1'b1;
            if (inc_wait)  cnt_wait   <= cnt_wait + 1'b1;
        end
    end

endmodule
